// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern-detector controller.
//   - FSM state encoding (plain localparams, legacy-compatible)
//   - PAT_MAX : longest supported pattern
//   - match_cfg_t : configuration bundle handed to the matcher
//   - len_mask() : mask selecting the low 'len' bits of an 8-bit pattern
package seq_detect_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ARMED = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;

    localparam int PAT_MAX = 8;

    typedef struct packed {
        logic [7:0] pattern;
        logic [3:0] len;
        logic       overlap;
    } match_cfg_t;

    // Lengths of 8 and above select the whole pattern; lengths above 8 never
    // match anyway because the fill counter stops at 8.
    function automatic logic [7:0] len_mask(input logic [3:0] len);
        logic [7:0] m;
        if (len >= 4'd8) begin
            m = 8'hFF;
        end else begin
            m = (8'h01 << len) - 8'h01;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// Mealy matcher for a serial bit stream.
//   clk, reset   : clock, asynchronous active-low reset
//   i_clear      : synchronous clear of history and fill (new run)
//   i_bit        : current serial bit
//   i_bit_valid  : i_bit is meaningful; state only advances when set
//   i_cfg        : latched pattern / length / overlap mode
//   o_z          : match pulse, combinational with i_bit
module seq_pattern_matcher
    import seq_detect_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  match_cfg_t i_cfg,
    output logic       o_z
);

    logic [6:0] r_hist;
    logic [3:0] r_fill;
    logic [7:0] w_cand;
    logic [3:0] w_fill_next;
    logic [7:0] w_mask;

    // Candidate window, saturating fill count and masked compare.
    always_comb begin
        w_cand = {r_hist, i_bit};
        w_mask = len_mask(i_cfg.len);
        if (r_fill >= 4'(PAT_MAX)) begin
            w_fill_next = 4'(PAT_MAX);
        end else begin
            w_fill_next = r_fill + 4'd1;
        end
        if (i_bit_valid && (i_cfg.len != 4'd0) && (w_fill_next >= i_cfg.len) &&
            (((w_cand ^ i_cfg.pattern) & w_mask) == 8'h00)) begin
            o_z = 1'b1;
        end else begin
            o_z = 1'b0;
        end
    end

    // History shift; a non-overlapping match restarts the window from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= 7'd0;
            r_fill <= 4'd0;
        end else if (i_clear) begin
            r_hist <= 7'd0;
            r_fill <= 4'd0;
        end else if (i_bit_valid) begin
            if (o_z && !i_cfg.overlap) begin
                r_hist <= 7'd0;
                r_fill <= 4'd0;
            end else begin
                r_hist <= w_cand[6:0];
                r_fill <= w_fill_next;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial controller feeding a Mealy pattern matcher.
//   clk, reset          : clock, asynchronous active-low reset
//   start / stop        : arm from IDLE / return to IDLE at a word boundary
//   cfg_*               : pattern, length, overlap mode, irq threshold (latched at start)
//   in_valid/in_data/in_ready : word handshake, words serialised MSB-first
//   bit_out / bit_valid : serial stream, one bit per clock while shifting
//   z                   : match pulse, same cycle as the completing bit
//   match_count         : saturating match counter since start
//   busy                : block not idle
//   irq / irq_clr       : sticky threshold interrupt and its clear
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             irq,
    input  logic             irq_clr
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    logic [1:0]       r_state;
    logic [W-1:0]     r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_pend;
    match_cfg_t       r_cfg;
    logic [CNT_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_count;
    logic             r_irq;

    logic             w_clear;
    logic             w_z;
    logic             w_irq_set;

    // Output decode from state; the word is shifted left so its MSB is the live bit.
    always_comb begin
        w_clear   = (r_state == ST_IDLE) && start;
        busy      = (r_state != ST_IDLE);
        bit_valid = (r_state == ST_SHIFT);
        bit_out   = bit_valid & r_word[W-1];
        if (r_state == ST_ARMED) begin
            in_ready = ~r_pend;
        end else begin
            in_ready = 1'b0;
        end
        z           = w_z;
        match_count = r_count;
        irq         = r_irq;
    end

    seq_pattern_matcher u_matcher (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_bit       (bit_out),
        .i_bit_valid (bit_valid),
        .i_cfg       (r_cfg),
        .o_z         (w_z)
    );

    // Control FSM and serialiser; a pending stop only takes effect between words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_word   <= {W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_pend   <= 1'b0;
            r_cfg    <= '0;
            r_thresh <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cfg.pattern <= cfg_pattern;
                        r_cfg.len     <= cfg_len;
                        r_cfg.overlap <= cfg_overlap;
                        r_thresh      <= cfg_thresh;
                        r_pend        <= 1'b0;
                        r_state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pend <= stop;
                        if (in_valid) begin
                            r_word  <= in_data;
                            r_idx   <= IDX_W'(W - 1);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_word <= {r_word[W-2:0], 1'b0};
                    if (r_idx == {IDX_W{1'b0}}) begin
                        r_pend <= 1'b0;
                        if (r_pend || stop) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_ARMED;
                        end
                    end else begin
                        r_idx  <= r_idx - IDX_W'(1);
                        r_pend <= r_pend | stop;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    // irq fires only on the increment that lands exactly on the threshold.
    always_comb begin
        if (w_z && !(&r_count) && (r_thresh != {CNT_W{1'b0}}) &&
            ((r_count + CNT_W'(1)) == r_thresh)) begin
            w_irq_set = 1'b1;
        end else begin
            w_irq_set = 1'b0;
        end
    end

    // Saturating match counter and sticky irq (set beats clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {CNT_W{1'b0}};
            r_irq   <= 1'b0;
        end else begin
            if (w_clear) begin
                r_count <= {CNT_W{1'b0}};
            end else if (w_z && !(&r_count)) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_irq <= w_irq_set | (r_irq & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [7:0]       cfg_pattern = 8'h00;
    logic [3:0]       cfg_len = 4'd0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_thresh = '0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_ready, bit_out, bit_valid, z, busy, irq;
    logic [CNT_W-1:0] match_count;
    logic             irq_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    seq_detect_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid), .z(z),
        .match_count(match_count), .busy(busy), .irq(irq), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_mode = 0;          // 0 idle, 1 armed, 2 shifting
    bit   m_bits[$];           // bits of the current word still to emit
    bit   m_stream[$];         // bits seen since the last clear (last 8 kept)
    bit   m_pend = 0;
    int   m_cnt = 0;
    bit   m_irq = 0;
    logic [7:0] m_pat = 8'h00;
    int   m_len = 0;
    bit   m_ov = 0;
    int   m_th = 0;

    function automatic bit model_z();
        bit b;
        if (m_mode != 2 || m_bits.size() == 0) return 1'b0;
        if (m_len == 0 || m_len > 8) return 1'b0;
        if (m_stream.size() + 1 < m_len) return 1'b0;
        b = m_bits[0];
        for (int k = 0; k < m_len; k++) begin
            bit bk;
            bk = (k == 0) ? b : m_stream[m_stream.size() - k];
            if (bk != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_bits.delete(); m_stream.delete(); m_pend = 0;
            m_cnt = 0; m_irq = 0; m_pat = 8'h00; m_len = 0; m_ov = 0; m_th = 0;
        end else begin
            bit zz, set, b;
            zz  = model_z();
            set = zz && (m_cnt != CMAX) && (m_th != 0) && (m_cnt + 1 == m_th);
            m_irq = set || (m_irq && !irq_clr);
            if (m_mode == 0) begin
                if (start) begin
                    m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap;
                    m_th = cfg_thresh; m_stream.delete(); m_cnt = 0; m_pend = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (m_pend) begin
                    m_mode = 0; m_pend = 0;
                end else begin
                    m_pend = stop;
                    if (in_valid) begin
                        for (int i = W - 1; i >= 0; i--) m_bits.push_back(in_data[i]);
                        m_mode = 2;
                    end
                end
            end else begin
                b = m_bits.pop_front();
                if (zz && m_cnt != CMAX) m_cnt++;
                if (zz && !m_ov) begin
                    m_stream.delete();
                end else begin
                    m_stream.push_back(b);
                    if (m_stream.size() > 8) void'(m_stream.pop_front());
                end
                if (m_bits.size() == 0) begin
                    m_mode = (m_pend || stop) ? 0 : 1;
                    m_pend = 0;
                end else begin
                    m_pend = m_pend || stop;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", busy, (m_mode != 0));
        chk("in_ready", in_ready, (m_mode == 1 && !m_pend));
        chk("bit_valid", bit_valid, (m_mode == 2));
        chk("bit_out", bit_out, (m_mode == 2) ? m_bits[0] : 1'b0);
        chk("z", z, model_z());
        chk("match_count", match_count, m_cnt);
        chk("irq", irq, m_irq);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                            input logic ov, input logic [7:0] th);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_thresh = th;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] data, input int clr_at, input int stop_at,
                             output logic [W-1:0] zmask, output logic [W-1:0] imask,
                             output int nbv);
        bit ok;
        ok = 1'b0; zmask = '0; imask = '0; nbv = 0;
        in_valid = 1'b1; in_data = data;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                zmask[i] = z; imask[i] = irq; nbv += int'(bit_valid);
                if (i == clr_at) irq_clr = 1'b1;
                if (i == stop_at) stop = 1'b1;
                @(posedge clk); #1;
                irq_clr = 1'b0; stop = 1'b0;
            end
        end
    endtask

    initial begin
        logic [W-1:0] zm, zm2, im;
        int nbv;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_count", match_count, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        tick();

        // Overlapping 1011
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        send_word(8'b10110110, -1, -1, zm, im, nbv);
        @(negedge clk);
        chk("ovl_zmask", zm, 8'h48);
        chk("ovl_count", match_count, 2);
        tick(); go_idle();

        // Non-overlapping
        do_start(8'h0B, 4'd4, 1'b0, 8'd0);
        send_word(8'b10110110, -1, -1, zm, im, nbv);
        @(negedge clk);
        chk("novl_zmask", zm, 8'h08);
        chk("novl_count", match_count, 1);
        tick(); go_idle();

        // Match spanning a word boundary
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        send_word(8'b00000010, -1, -1, zm, im, nbv);
        send_word(8'b11000000, -1, -1, zm2, im, nbv);
        @(negedge clk);
        chk("xw_zmask0", zm, 8'h00);
        chk("xw_zmask1", zm2, 8'h02);
        chk("xw_count", match_count, 1);
        tick(); go_idle();

        // Threshold interrupt, rising the cycle after the second match
        do_start(8'h0B, 4'd4, 1'b1, 8'd2);
        send_word(8'b10110110, -1, -1, zm, im, nbv);
        chk("thr_imask", im, 8'h80);
        go_idle();
        do_start(8'h0B, 4'd4, 1'b1, 8'd2);
        @(negedge clk);
        chk("thr_irq_kept_on_start", irq, 1);
        tick();
        send_word(8'b10110110, 6, -1, zm, im, nbv);
        chk("thr_set_beats_clr", im, 8'hFF);
        @(negedge clk);
        chk("thr_irq_after", irq, 1);
        tick();
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        @(negedge clk);
        chk("irq_cleared", irq, 0);
        tick(); go_idle();

        // Length 0 disables matching
        do_start(8'hFF, 4'd0, 1'b1, 8'd0);
        send_word(8'hFF, -1, -1, zm, im, nbv);
        @(negedge clk);
        chk("len0_zmask", zm, 8'h00);
        chk("len0_count", match_count, 0);
        tick(); go_idle();

        // start while busy is ignored
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        do_start(8'hFF, 4'd1, 1'b0, 8'd1);
        send_word(8'b10110110, -1, -1, zm, im, nbv);
        @(negedge clk);
        chk("busy_start_zmask", zm, 8'h48);
        chk("busy_start_irq", irq, 0);
        tick(); go_idle();

        // stop mid-word: whole word emitted, then IDLE
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        send_word(8'b10110110, -1, 2, zm, im, nbv);
        chk("stop_nbits", nbv, 8);
        chk("stop_zmask", zm, 8'h48);
        @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_ready", in_ready, 0);
        tick();

        // Asynchronous reset in the middle of a word
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        in_valid = 1'b1; in_data = 8'b10110110;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", bit_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", bit_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bit", bit_out, 0);
        chk("arst_count", match_count, 0);
        reset = 1'b1;
        tick();

        // Recovery after reset
        do_start(8'h0B, 4'd4, 1'b1, 8'd0);
        send_word(8'b10110110, -1, -1, zm, im, nbv);
        @(negedge clk);
        chk("post_rst_zmask", zm, 8'h48);
        chk("post_rst_count", match_count, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
